// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Optional early-out for zero operands is enabled by the MULTDIV_EARLY_OUT_EN macro.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam int DATA_WIDTH_DEFAULT  = 32;
    localparam int RSTATUS_REG_DEFAULT = 30;
    localparam int MUL_STATUS_DEFAULT  = 4;
    localparam int DIV_STATUS_DEFAULT  = 5;

    function automatic int cnt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/multdiv_datapath.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per step.
// product/quotient present the post-step values so the caller can register them on the last step.
module multdiv_datapath
    import multdiv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                      clock,
    input  logic                      load,
    input  logic                      step,
    input  logic                      is_div,
    input  logic [DATA_WIDTH-1:0]     mag_a,
    input  logic [DATA_WIDTH-1:0]     mag_b,
    output logic [2*DATA_WIDTH-1:0]   product,
    output logic [DATA_WIDTH-1:0]     quotient
);

    logic [2*DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0]   quot;
    logic [DATA_WIDTH-1:0]   rem;
    logic [DATA_WIDTH-1:0]   operand_b;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     rem_shift;
    logic [DATA_WIDTH:0]     rem_diff;
    logic [2*DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0]   quot_next;
    logic [DATA_WIDTH-1:0]   rem_next;

    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
        acc_next  = {mul_sum, acc[DATA_WIDTH-1:1]};
        rem_shift = {rem, quot[DATA_WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, operand_b};
        if (!rem_diff[DATA_WIDTH]) begin
            rem_next  = rem_diff[DATA_WIDTH-1:0];
            quot_next = {quot[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = rem_shift[DATA_WIDTH-1:0];
            quot_next = {quot[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // NOTE: no reset on these registers; load initialises all of them before any step uses them.
    always_ff @(posedge clock) begin
        if (load) begin
            acc       <= {{DATA_WIDTH{1'b0}}, mag_a};
            quot      <= mag_a;
            rem       <= '0;
            operand_b <= mag_b;
        end else if (step) begin
            if (is_div) begin
                quot <= quot_next;
                rem  <= rem_next;
            end else begin
                acc <= acc_next;
            end
        end
    end

    assign product  = acc_next;
    assign quotient = quot_next;

endmodule

// File: rtl/multdiv_sequencer.sv
// Execute-stage mul/div controller: stalls F/D/X while the datapath iterates, then releases the result.
// Define MULTDIV_EARLY_OUT_EN to finish after one RUN cycle when an operand makes the answer trivial.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int RSTATUS_REG = RSTATUS_REG_DEFAULT,
    parameter int MUL_STATUS  = MUL_STATUS_DEFAULT,
    parameter int DIV_STATUS  = DIV_STATUS_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [4:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] op_A,
    input  logic [DATA_WIDTH-1:0] op_B,
    input  logic [4:0]            dest_rd,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            result_rd,
    output logic                  exception
);

    localparam int                    CNT_W     = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    neg_q;
    logic                    is_div_q;
    logic                    div_zero_q;
    logic                    div_ovf_q;
    logic [4:0]              rd_q;

    logic                    start;
    logic                    start_div;
    logic                    last_step;
    logic                    early_done;
    logic [DATA_WIDTH-1:0]   mag_a;
    logic [DATA_WIDTH-1:0]   mag_b;
    logic [2*DATA_WIDTH-1:0] product;
    logic [2*DATA_WIDTH-1:0] prod_signed;
    logic [DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]   quot_signed;
    logic                    mul_ovf;
    logic                    exc_next;
    logic [DATA_WIDTH-1:0]   result_next;

    assign start_div = (alu_op == ALU_DIV);
    assign start     = (state == IDLE) && instr_valid && ((alu_op == ALU_MUL) || start_div);
    assign stall     = start || (state == RUN);
    assign busy      = (state != IDLE);
    assign mag_a     = op_A[DATA_WIDTH-1] ? -op_A : op_A;
    assign mag_b     = op_B[DATA_WIDTH-1] ? -op_B : op_B;

`ifdef MULTDIV_EARLY_OUT_EN
    logic early_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            early_q <= 1'b0;
        end else if (start) begin
            early_q <= (op_B == '0) || (!start_div && (op_A == '0));
        end
    end

    assign early_done = early_q;
`else
    assign early_done = 1'b0;
`endif

    assign last_step = (cnt == LAST_STEP) || early_done;

    multdiv_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .clock    (clock),
        .load     (start),
        .step     (state == RUN),
        .is_div   (is_div_q),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .product  (product),
        .quotient (quotient)
    );

    // An early-out multiply has a zero operand, so its product is forced rather than iterated.
    always_comb begin
        prod_signed = early_done ? '0 : product;
        if (neg_q) begin
            prod_signed = -prod_signed;
        end
        quot_signed = neg_q ? -quotient : quotient;
        mul_ovf     = !((&prod_signed[2*DATA_WIDTH-1:DATA_WIDTH-1]) ||
                        (~|prod_signed[2*DATA_WIDTH-1:DATA_WIDTH-1]));
        exc_next    = is_div_q ? (div_zero_q || div_ovf_q) : mul_ovf;
        if (exc_next) begin
            result_next = is_div_q ? DATA_WIDTH'(DIV_STATUS) : DATA_WIDTH'(MUL_STATUS);
        end else begin
            result_next = is_div_q ? quot_signed : prod_signed[DATA_WIDTH-1:0];
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            exception  <= 1'b0;
            result     <= '0;
            result_rd  <= '0;
            neg_q      <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            rd_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        neg_q      <= op_A[DATA_WIDTH-1] ^ op_B[DATA_WIDTH-1];
                        is_div_q   <= start_div;
                        div_zero_q <= (op_B == '0);
                        div_ovf_q  <= (op_A == MIN_NEG) && (op_B == '1);
                        rd_q       <= dest_rd;
                        cnt        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        exception <= exc_next;
                        result    <= result_next;
                        result_rd <= exc_next ? 5'(RSTATUS_REG) : rd_q;
                    end
                end
                DONE: begin
                    // alu_op is deliberately ignored here so the held instruction cannot retrigger.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed vector bench for multdiv_sequencer: latency, results, exceptions, back-to-back and reset abort.
// Expected latency follows MULTDIV_EARLY_OUT_EN when the bench is built with it.
module tb_multdiv_sequencer;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [4:0]  alu_op;
    logic [31:0] op_A;
    logic [31:0] op_B;
    logic [4:0]  dest_rd;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        exception;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_result;
        logic [4:0]  exp_rd;
        logic        exp_exc;
        bit          early;
        string       name;
    } vec_t;

    vec_t vecs[14];

    multdiv_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .alu_op      (alu_op),
        .op_A        (op_A),
        .op_B        (op_B),
        .dest_rd     (dest_rd),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_rd   (result_rd),
        .exception   (exception)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change after the falling edge; outputs are sampled 1 ns later, well away from posedge.
    task automatic step_cycle(input logic rst, input logic v, input logic [4:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clock);
        reset       = rst;
        instr_valid = v;
        alu_op      = op;
        op_A        = a;
        op_B        = b;
        dest_rd     = rd;
        #1;
    endtask

    task automatic run_op(input vec_t v);
        int          lat;
        int          stall_cnt;
        int          done_at;
        logic        stall_at_done;
        logic [31:0] r;
        logic [4:0]  rr;
        logic        e;
        lat = 33;
`ifdef MULTDIV_EARLY_OUT_EN
        if (v.early) lat = 2;
`endif
        stall_cnt     = 0;
        done_at       = -1;
        stall_at_done = 1'b0;
        r             = '0;
        rr            = '0;
        e             = 1'b0;
        for (int c = 0; c < 60 && done_at < 0; c++) begin
            step_cycle(1'b0, 1'b1, v.op, v.a, v.b, v.rd);
            if (stall) stall_cnt++;
            if (done) begin
                done_at       = c;
                stall_at_done = stall;
                r             = result;
                rr            = result_rd;
                e             = exception;
            end
        end
        step_cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        check({v.name, " done_cycle"},    32'(done_at), 32'(lat));
        check({v.name, " stall_cycles"},  32'(stall_cnt), 32'(lat));
        check({v.name, " stall_in_done"}, 32'(stall_at_done), 32'd0);
        check({v.name, " done_after"},    32'(done), 32'd0);
        check({v.name, " busy_after"},    32'(busy), 32'd0);
        check({v.name, " result"},        r, v.exp_result);
        check({v.name, " result_rd"},     32'(rr), 32'(v.exp_rd));
        check({v.name, " exception"},     32'(e), 32'(v.exp_exc));
    endtask

    initial begin
        int          n_done;
        int          first_done;
        int          second_done;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        s34;
        logic        b34;
        logic        saw_stall;
        logic        saw_busy;

        vecs[0]  = '{ALU_MUL, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 5'd5,  1'b0, 1'b0, "mul_7_x_m3"};
        vecs[1]  = '{ALU_DIV, 32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD, 5'd9,  1'b0, 1'b0, "div_m7_by_2"};
        vecs[2]  = '{ALU_DIV, 32'd5,          32'd0,        5'd12, 32'd5,        5'd30, 1'b1, 1'b1, "div_5_by_0"};
        vecs[3]  = '{ALU_MUL, 32'h00010000,   32'h00010000, 5'd3,  32'd4,        5'd30, 1'b1, 1'b0, "mul_ovf_2p32"};
        vecs[4]  = '{ALU_MUL, 32'h7FFFFFFF,   32'd1,        5'd7,  32'h7FFFFFFF, 5'd7,  1'b0, 1'b0, "mul_max_x_1"};
        vecs[5]  = '{ALU_DIV, 32'h80000000,   32'hFFFFFFFF, 5'd4,  32'd5,        5'd30, 1'b1, 1'b0, "div_min_by_m1"};
        vecs[6]  = '{ALU_MUL, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  32'd1,        5'd1,  1'b0, 1'b0, "mul_m1_x_m1"};
        vecs[7]  = '{ALU_DIV, 32'd100,        32'd7,        5'd2,  32'd14,       5'd2,  1'b0, 1'b0, "div_100_by_7"};
        vecs[8]  = '{ALU_MUL, 32'd0,          32'd1234,     5'd6,  32'd0,        5'd6,  1'b0, 1'b1, "mul_0_x_1234"};
        vecs[9]  = '{ALU_MUL, 32'h80000000,   32'd1,        5'd8,  32'h80000000, 5'd8,  1'b0, 1'b0, "mul_min_x_1"};
        vecs[10] = '{ALU_MUL, 32'h00008000,   32'hFFFF0000, 5'd10, 32'h80000000, 5'd10, 1'b0, 1'b0, "mul_to_min"};
        vecs[11] = '{ALU_MUL, 32'h00008000,   32'h00010000, 5'd11, 32'd4,        5'd30, 1'b1, 1'b0, "mul_ovf_2p31"};
        vecs[12] = '{ALU_DIV, 32'h80000000,   32'd1,        5'd14, 32'h80000000, 5'd14, 1'b0, 1'b0, "div_min_by_1"};
        vecs[13] = '{ALU_DIV, 32'd7,          32'hFFFFFFF9, 5'd13, 32'hFFFFFFFF, 5'd13, 1'b0, 1'b0, "div_7_by_m7"};

        // Reset state.
        step_cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        step_cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        step_cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        check("reset stall",     32'(stall), 32'd0);
        check("reset busy",      32'(busy), 32'd0);
        check("reset done",      32'(done), 32'd0);
        check("reset exception", 32'(exception), 32'd0);
        check("reset result",    result, 32'd0);
        check("reset result_rd", 32'(result_rd), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i]);
        end

        // Non-mul/div ops and bubbles carrying a mul opcode must never stall.
        saw_stall = 1'b0;
        saw_busy  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step_cycle(1'b0, 1'b1, 5'b00000, 32'd3, 32'd4, 5'd2);
            saw_stall |= stall;
            saw_busy  |= busy;
        end
        for (int c = 0; c < 3; c++) begin
            step_cycle(1'b0, 1'b0, ALU_MUL, 32'd3, 32'd4, 5'd2);
            saw_stall |= stall;
            saw_busy  |= busy;
        end
        check("nonmuldiv stall", 32'(saw_stall), 32'd0);
        check("nonmuldiv busy",  32'(saw_busy), 32'd0);

        // Back-to-back: mul 3 * -4 then div 100 / -10 entering DX in cycle 34.
        n_done      = 0;
        first_done  = -1;
        second_done = -1;
        r1 = '0; r2 = '0; rd1 = '0; rd2 = '0; s34 = 1'b0; b34 = 1'b1;
        for (int c = 0; c < 72; c++) begin
            if (c <= 33)      step_cycle(1'b0, 1'b1, ALU_MUL, 32'd3,   32'hFFFFFFFC, 5'd17);
            else if (c <= 67) step_cycle(1'b0, 1'b1, ALU_DIV, 32'd100, 32'hFFFFFFF6, 5'd18);
            else              step_cycle(1'b0, 1'b0, 5'd0,    32'd0,   32'd0,        5'd0);
            if (c == 34) begin
                s34 = stall;
                b34 = busy;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin first_done  = c; r1 = result; rd1 = result_rd; end
                if (n_done == 2) begin second_done = c; r2 = result; rd2 = result_rd; end
            end
        end
        check("b2b done_count",   32'(n_done), 32'd2);
        check("b2b first_done",   32'(first_done), 32'd33);
        check("b2b stall_c34",    32'(s34), 32'd1);
        check("b2b busy_c34",     32'(b34), 32'd0);
        check("b2b second_done",  32'(second_done), 32'd67);
        check("b2b mul_result",   r1, 32'hFFFFFFF4);
        check("b2b mul_rd",       32'(rd1), 32'd17);
        check("b2b div_result",   r2, 32'hFFFFFFF6);
        check("b2b div_rd",       32'(rd2), 32'd18);

        // Reset asserted in cycle 10 of the op abandons it without a done pulse.
        for (int c = 0; c < 10; c++) begin
            step_cycle(1'b0, 1'b1, ALU_MUL, 32'd5, 32'd6, 5'd3);
        end
        step_cycle(1'b1, 1'b1, ALU_MUL, 32'd5, 32'd6, 5'd3);
        step_cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        check("abort stall",  32'(stall), 32'd0);
        check("abort busy",   32'(busy), 32'd0);
        check("abort result", result, 32'd0);
        n_done = (done === 1'b1) ? 1 : 0;
        for (int c = 0; c < 40; c++) begin
            step_cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
            if (done === 1'b1) n_done++;
        end
        check("abort no_done", 32'(n_done), 32'd0);
        run_op('{ALU_MUL, 32'd5, 32'd6, 5'd3, 32'd30, 5'd3, 1'b0, 1'b0, "mul_after_abort"});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
